popcount_unary_gen: RTL and testbench

//  Inverse of the popcount22 family: takes a count k and a rotation r and

---
 rtl/popcount_unary_gen_if.sv | 25 ++
 rtl/popcount_unary_gen.sv | 92 +++++++++
 tb/tb_popcount_unary_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/popcount_unary_gen_if.sv
// Request/response handshake bundle for the unary vector generator.
// Requests carry count/rotation; responses carry the built vector.
interface popcount_unary_gen_if #(
  parameter int N  = 22,
  parameter int CW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic [CW-1:0] in_rot;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic          out_sat;

  modport master (
    output in_valid, in_count, in_rot, out_ready,
    input  in_ready, out_valid, out_vec, out_sat
  );

  modport slave (
    input  in_valid, in_count, in_rot, out_ready,
    output in_ready, out_valid, out_vec, out_sat
  );
endinterface

// File: rtl/popcount_unary_gen.sv
// Serial generator of an N-bit vector with min(k,N) ones rotated by r mod N.
// One bit filled per cycle, then one rotate step per cycle.
module popcount_unary_gen #(
  parameter int N  = 22,
  parameter int CW = 5
) (
  input logic                clk,
  input logic                rst,
  popcount_unary_gen_if.slave bus
);
  localparam logic [CW-1:0] NC = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ROT,
    OUT
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  vec, vec_n, vec_o;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] rot, rot_n;
  logic          sat, sat_n, sat_o;

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    rot_n   = rot;
    sat_n   = sat;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sat_n = bus.in_count > NC;
          cnt_n = sat_n ? NC : bus.in_count;
          rot_n = (bus.in_rot >= NC) ? bus.in_rot - NC : bus.in_rot;
          vec_n = '0;
          if (cnt_n != '0)      state_n = FILL;
          else if (rot_n != '0) state_n = ROT;
          else                  state_n = OUT;
        end
      end
      FILL: begin
        vec_n = {vec[N-2:0], 1'b1};
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1))
          state_n = (rot != '0) ? ROT : OUT;
      end
      ROT: begin
        vec_n = {vec[N-2:0], vec[N-1]};
        rot_n = rot - 1'b1;
        if (rot == CW'(1))
          state_n = OUT;
      end
      OUT: begin
        if (bus.out_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Presented vector lives in its own register so it stays put while
  // the next request is being built.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      cnt   <= '0;
      rot   <= '0;
      sat   <= 1'b0;
      vec_o <= '0;
      sat_o <= 1'b0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      cnt   <= cnt_n;
      rot   <= rot_n;
      sat   <= sat_n;
      if (state_n == OUT && state != OUT) begin
        vec_o <= vec_n;
        sat_o <= sat_n;
      end
    end
  end

  assign bus.in_ready  = !rst && (state == IDLE);
  assign bus.out_valid = !rst && (state == OUT);
  assign bus.out_vec   = rst ? '0 : vec_o;
  assign bus.out_sat   = !rst && sat_o;
endmodule

// File: tb/tb_popcount_unary_gen.sv
// Bench for popcount_unary_gen: directed table, corner sequences and
// a shuffled sweep of every (k,r) pair against an arithmetic model.
module tb_popcount_unary_gen;
  localparam int N  = 22;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_unary_gen_if #(.N(N), .CW(CW)) bus ();

  popcount_unary_gen #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    int          r;
    logic [21:0] vec;
    logic        sat;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] ref_vec(input int k, input int r);
    logic [21:0] v;
    int kk, rr;
    kk = (k > N) ? N : k;
    rr = r % N;
    v = '0;
    for (int i = 0; i < N; i++)
      if (i < kk) v[(i + rr) % N] = 1'b1;
    return v;
  endfunction

  function automatic int ref_lat(input int k, input int r);
    return 1 + ((k > N) ? N : k) + (r % N);
  endfunction

  task automatic run_req(input int k, input int r,
                         output logic [21:0] v, output logic s,
                         output int lat, output bit held);
    int w;
    logic [21:0] prev;
    bus.in_count = CW'(k);
    bus.in_rot   = CW'(r);
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    prev = bus.out_vec;
    held = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      if (bus.out_vec !== prev) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    v = bus.out_vec;
    s = bus.out_sat;
  endtask

  vec_t        tbl[8];
  logic [21:0] v, hv;
  logic        s;
  int          lat;
  bit          held;
  int          order[1024];
  int          all_held;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.in_rot    = '0;
    bus.out_ready = 1'b1;

    tbl[0] = '{0,  0,  22'h000000, 1'b0, 1};
    tbl[1] = '{5,  0,  22'h00001F, 1'b0, 6};
    tbl[2] = '{5,  3,  22'h0000F8, 1'b0, 9};
    tbl[3] = '{22, 21, 22'h3FFFFF, 1'b0, 44};
    tbl[4] = '{31, 0,  22'h3FFFFF, 1'b1, 23};
    tbl[5] = '{3,  23, 22'h00000E, 1'b0, 5};
    tbl[6] = '{1,  21, 22'h200000, 1'b0, 23};
    tbl[7] = '{22, 22, 22'h3FFFFF, 1'b0, 23};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_vec", 64'(bus.out_vec), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_out_sat", 64'(bus.out_sat), 64'd0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].k, tbl[i].r, v, s, lat, held);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("tbl%0d_vec", i), 64'(v), 64'(tbl[i].vec));
      chk($sformatf("tbl%0d_sat", i), 64'(s), 64'(tbl[i].sat));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_hold", i), 64'(held), 64'd1);
    end

    // back-pressure in OUT
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_req(7, 2, v, s, lat, held);
    hv = v;
    chk("bp_vec", 64'(v), 64'(ref_vec(7, 2)));
    bus.in_count = 5'd3;
    bus.in_rot   = 5'd0;
    bus.in_valid = 1'b1;
    all_held = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.out_vec !== hv || bus.in_ready)
        all_held = 0;
    end
    chk("bp_stable", 64'(all_held), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_hold", 64'(bus.out_vec), 64'(hv));

    // reset while filling
    bus.in_count = 5'd10;
    bus.in_rot   = 5'd4;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_vec", 64'(bus.out_vec), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_out", 64'(bus.out_valid), 64'd0);

    // shuffled sweep of every (k,r)
    for (int i = 0; i < 1024; i++) order[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 1024; i++) begin
      int k, r;
      k = order[i] / 32;
      r = order[i] % 32;
      run_req(k, r, v, s, lat, held);
      chk($sformatf("sw_k%0d_r%0d_vec", k, r), 64'(v), 64'(ref_vec(k, r)));
      chk($sformatf("sw_k%0d_r%0d_pop", k, r), 64'($countones(v)),
          64'((k > N) ? N : k));
      chk($sformatf("sw_k%0d_r%0d_sat", k, r), 64'(s), 64'(k > N));
      chk($sformatf("sw_k%0d_r%0d_lat", k, r), 64'(lat), 64'(ref_lat(k, r)));
      chk($sformatf("sw_k%0d_r%0d_hold", k, r), 64'(held), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
